aes_iter_core: RTL and testbench
================================

// Module: aes_iter_core
// PURPOSE
//  Iterative AES block engine; successor to the fully unrolled AES-128 encrypt/decrypt top.
//  Key length is parametrised: 128/192/256.
//  Key expansion is on-chip, one word/cycle, into a round-key register file.
//  Processes one 128-bit block at a time, one round per cycle, encrypt or decrypt per block,
//  with valid/ready handshakes on key, input and output.
//  Sits between the plaintext source and cipher-text sink; replaces the separate expand/schedule/encrypt/decrypt path.
// PARAMETERS
//  KEY_BITS  128  key length; legal values 128/192/256; any other value is an elaboration error
//  INV_EN    1    1 = decrypt datapath present; 0 = in_decrypt ignored, encrypt only
// PORTS
//  clk         in   1         single clock, rising edge
//  rst         in   1         synchronous, active-high reset
//  key_valid   in   1         key_in valid
//  key_ready   out  1         core accepts a new key
//  key_in      in   KEY_BITS  cipher key, FIPS-197 byte order (byte 0 = MSBs)
//  in_valid    in   1         in_data/in_decrypt valid
//  in_ready    out  1         core accepts a block
//  in_decrypt  in   1         1 = inverse cipher for this block
//  in_data     in   128       plaintext or ciphertext
//  out_valid   out  1         out_data valid; held until out_ready
//  out_ready   in   1         sink accepts out_data
//  out_data    out  128       result block
// BEHAVIOUR
//  Derived values: Nk=KEY_BITS/32; Nr=Nk+6 (10/12/14); W=4*(Nr+1) words (44/52/60).
//  Reset: state=NOKEY; key_ready=1; in_ready=0; out_valid=0; out_data=0; round-key file marked invalid.
//   Reset mid-expansion or mid-block aborts and discards all work.
//  FSM states: NOKEY, KEXP, READY, ROUND, DONE.
//   key_ready=1 in NOKEY and READY only.
//   in_ready=1 in READY only.
//   out_valid=1 in DONE only.
//  Key load (state NOKEY/READY):
//   - key_valid&&key_ready -> KEXP.
//   - w[0..Nk-1] load from key_in in the accept cycle.
//   - Then one word w[i] per cycle, i=Nk..W-1:
//     w[i]=w[i-Nk]^f(w[i-1]), with f=SubWord(RotWord)^Rcon when i%Nk==0.
//   - Extra rule for Nk=8 only: f=SubWord when i%8==4.
//   - Otherwise f=identity.
//   - KEXP lasts W-Nk cycles (40/46/52), then -> READY.
//   - Key accepted in READY replaces the old key.
//  Block accept (READY, in_valid&&in_ready, cycle N):
//   - st <= in_data ^ rk[0] (enc) or rk[Nr] (dec); capture mode bit; -> ROUND.
//  ROUND, cycles N+1..N+Nr, round r=1..Nr:
//   - Encrypt: SubBytes, ShiftRows, MixColumns, ^rk[r].
//   - Decrypt: InvShiftRows, InvSubBytes, ^rk[Nr-r], InvMixColumns.
//   - (Inv)MixColumns is omitted in round Nr.
//   - After round Nr -> DONE; out_data<=st.
//  Latency: out_valid first high in cycle N+Nr+1.
//  DONE: hold out_data/out_valid until out_ready=1. Then -> READY next cycle.
//  Throughput: one block per Nr+2 cycles with out_ready tied 1.
//  No overlap: a new key or block is never accepted while in KEXP, ROUND or DONE.
//  in_valid in NOKEY or KEXP: ignored, no accept.
//  Simultaneous key_valid and in_valid in READY: key wins; the block stalls until READY returns.
//  GF(2^8) arithmetic: xtime uses reduction polynomial 0x11B.
//  Rcon sequence 01,02,04,...,1B,36 (8-bit, reduced).
//  The round counter wraps only via FSM exit; no modular reuse.
// TESTING
//  1. KEY_BITS=128. Key 000102..0f, pt 00112233445566778899aabbccddeeff
//     -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//     KEXP = 40 cycles; out_valid exactly 11 cycles after accept.
//  2. KEY_BITS=192. Key 00..17, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191.
//     KEY_BITS=256. Key 00..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089.
//     Latency 13 / 15 cycles respectively.
//  3. Decrypt each ciphertext above (in_decrypt=1) -> 00112233445566778899aabbccddeeff.
//     INV_EN=0 with in_decrypt=1 -> encrypt result returned.
//  4. Backpressure: hold out_ready=0 for 20 cycles -> out_data stable, in_ready=0.
//     Release out_ready -> READY next cycle.
//     Back-to-back blocks with out_ready=1 -> accepts exactly Nr+2 cycles apart.
//  5. Key 2b7e151628aed2a6abf7158809cf4f3c loaded while READY, then pt 3243f6a8885a308d313198a2e0370734
//     -> 3925841d02dc09fbdc118597196a0b32.
//     key_valid and in_valid in the same cycle -> key accepted, block waits.
//  6. Assert rst in mid-KEXP and in mid-ROUND -> next cycle: out_valid=0, in_ready=0, key_ready=1.
//     in_valid is ignored until a new key is loaded.

Source files
------------

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 engine: on-chip key expansion (one word per cycle) into a
// round-key file, then one round per cycle per block, encrypt or decrypt per block.
module aes_iter_core #(
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned INV_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_decrypt,
  input  logic [127:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);
  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), avoiding a 256-entry table
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int unsigned i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [3:0][7:0] a, b, k;
    a = col;
    k = inv ? {8'h0e, 8'h0b, 8'h0d, 8'h09} : {8'h02, 8'h03, 8'h01, 8'h01};
    for (int unsigned i = 0; i < 4; i++) begin
      b[2'(3 - i)] = '0;
      for (int unsigned j = 0; j < 4; j++)
        b[2'(3 - i)] = b[2'(3 - i)] ^ gmul(a[2'(3 - j)], k[2'd3 - 2'(j - i)]);
    end
    return b;
  endfunction

  // Byte n of a block lives at packed index 15-n (byte 0 = MSBs); row r of column c is byte 4c+r
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
    logic [15:0][7:0] a, b;
    logic [3:0][31:0] cw;
    a = s;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        b[4'(15 - (4 * c + r))] = sbox(a[4'(15 - (4 * ((c + r) % 4) + r))]);
    cw = b;
    if (!last)
      for (int unsigned c = 0; c < 4; c++) cw[2'(3 - c)] = mix_col(cw[2'(3 - c)], 1'b0);
    return cw ^ rk;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
    logic [15:0][7:0] a, b;
    logic [3:0][31:0] cw;
    a = s;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        b[4'(15 - (4 * c + r))] = inv_sbox(a[4'(15 - (4 * ((c + 4 - r) % 4) + r))]);
    cw = b ^ rk;
    if (!last)
      for (int unsigned c = 0; c < 4; c++) cw[2'(3 - c)] = mix_col(cw[2'(3 - c)], 1'b1);
    return cw;
  endfunction

  typedef enum logic [2:0] {NOKEY, KEXP, READY, ROUND, DONE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         w_q [NW];
  logic [31:0]         w_d [NW];
  logic [5:0]          kidx_q, kidx_d;
  logic [2:0]          kph_q, kph_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [3:0]          rnd_q, rnd_d;
  logic                dec_q, dec_d;
  logic [127:0]        st_q, st_d, out_q, out_d;

  logic [NK-1:0][31:0] key_w;
  logic                key_acc, blk_acc, last_rnd, dec_in;
  logic [31:0]         t, f;
  logic [3:0]          rk_idx;
  logic [5:0]          rk_base;
  logic [127:0]        rk;

  assign key_w    = key_in;
  assign key_acc  = key_valid && key_ready;
  assign blk_acc  = in_valid && in_ready;
  assign last_rnd = (rnd_q == 4'(NR));
  assign dec_in   = (INV_EN != 0) && in_decrypt;
  assign out_data = out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NOKEY;
      kidx_q  <= 6'(NK);
      kph_q   <= '0;
      rcon_q  <= 8'h01;
      rnd_q   <= '0;
      dec_q   <= 1'b0;
      st_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      kidx_q  <= kidx_d;
      kph_q   <= kph_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      dec_q   <= dec_d;
      st_q    <= st_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) w_q <= w_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NOKEY:   if (key_acc) state_d = KEXP;
      KEXP:    if (kidx_q == 6'(NW - 1)) state_d = READY;
      READY:   if (key_acc) state_d = KEXP;
               else if (blk_acc) state_d = ROUND;
      ROUND:   if (last_rnd) state_d = DONE;
      DONE:    if (out_ready) state_d = READY;
      default: state_d = NOKEY;
    endcase
  end

  // A pending key masks in_ready so the block visibly stalls while the key wins
  always_comb begin
    key_ready = (state_q == NOKEY) || (state_q == READY);
    in_ready  = (state_q == READY) && !key_valid;
    out_valid = (state_q == DONE);
  end

  always_comb begin
    w_d    = w_q;
    kidx_d = kidx_q;
    kph_d  = kph_q;
    rcon_d = rcon_q;
    rnd_d  = rnd_q;
    dec_d  = dec_q;
    st_d   = st_q;
    out_d  = out_q;

    t = w_q[kidx_q - 6'd1];
    if (kph_q == '0)
      f = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon_q, 24'h0};
    else if (NK == 8 && kph_q == 3'd4)
      f = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    else
      f = t;

    if (state_q == READY) rk_idx = dec_in ? 4'(NR) : 4'd0;
    else                  rk_idx = dec_q ? 4'(NR) - rnd_q : rnd_q;
    rk_base = {rk_idx, 2'b00};
    rk = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};

    if (key_acc) begin
      for (int unsigned i = 0; i < NK; i++) w_d[6'(i)] = key_w[3'(NK - 1 - i)];
      kidx_d = 6'(NK);
      kph_d  = '0;
      rcon_d = 8'h01;
    end else if (state_q == KEXP) begin
      w_d[kidx_q] = w_q[kidx_q - 6'(NK)] ^ f;
      kidx_d      = kidx_q + 6'd1;
      kph_d       = (kph_q == 3'(NK - 1)) ? 3'd0 : kph_q + 3'd1;
      if (kph_q == '0) rcon_d = xtime(rcon_q);
    end

    if (blk_acc) begin
      st_d  = in_data ^ rk;
      dec_d = dec_in;
      rnd_d = 4'd1;
    end else if (state_q == ROUND) begin
      st_d  = dec_q ? dec_round(st_q, rk, last_rnd) : enc_round(st_q, rk, last_rnd);
      rnd_d = rnd_q + 4'd1;
      if (last_rnd) out_d = st_d;
    end
  end
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed FIPS-197 vectors across key sizes, decrypt, INV_EN=0, backpressure,
// back-to-back throughput, key/block collision and reset aborts.
module tb_aes_iter_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   kv, iv;
  logic         in_decrypt, out_ready;
  logic [255:0] key_bus;
  logic [127:0] in_data;
  wire  [3:0]   kr, ir, ov;
  wire  [127:0] od [4];

  int unsigned checks = 0, failures = 0;

  localparam logic [255:0] K_SEQ  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K_APPC = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_APPC = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_APPC = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_iter_core #(.KEY_BITS(128), .INV_EN(1)) u_aes128 (
    .clk(clk), .rst(rst), .key_valid(kv[0]), .key_ready(kr[0]), .key_in(key_bus[255:128]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_decrypt(in_decrypt), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));
  aes_iter_core #(.KEY_BITS(192), .INV_EN(1)) u_aes192 (
    .clk(clk), .rst(rst), .key_valid(kv[1]), .key_ready(kr[1]), .key_in(key_bus[255:64]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_decrypt(in_decrypt), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));
  aes_iter_core #(.KEY_BITS(256), .INV_EN(1)) u_aes256 (
    .clk(clk), .rst(rst), .key_valid(kv[2]), .key_ready(kr[2]), .key_in(key_bus),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_decrypt(in_decrypt), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));
  aes_iter_core #(.KEY_BITS(128), .INV_EN(0)) u_aes128_enc (
    .clk(clk), .rst(rst), .key_valid(kv[3]), .key_ready(kr[3]), .key_in(key_bus[255:128]),
    .in_valid(iv[3]), .in_ready(ir[3]), .in_decrypt(in_decrypt), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int sel, input logic [255:0] key, input int kexp, input string tag);
    int n;
    n = 0;
    while (!kr[sel] && n < 200) begin tick(); n++; end
    key_bus = key;
    kv[sel] = 1'b1;
    tick();
    kv[sel] = 1'b0;
    n = 0;
    while (!kr[sel] && n < 200) begin
      if (n == 5) check({tag, "_inrdy_in_kexp"}, ir[sel], 0);
      tick();
      n++;
    end
    check({tag, "_kexp_cycles"}, n, kexp);
  endtask

  task automatic run_block(input int sel, input logic dec, input logic [127:0] data,
                           input logic [127:0] exp, input int nr, input int hold, input string tag);
    int   n;
    logic stable;
    stable = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!ir[sel] && n < 200) begin tick(); n++; end
    in_data = data;
    in_decrypt = dec;
    iv[sel] = 1'b1;
    tick();
    iv[sel] = 1'b0;
    n = 1;
    while (!ov[sel] && n < 200) begin tick(); n++; end
    check({tag, "_latency"}, n, nr + 1);
    check({tag, "_data"}, od[sel], exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (od[sel] !== exp || !ov[sel] || ir[sel]) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, stable, 1);
    out_ready = 1'b1;
    tick();
    check({tag, "_ready_after"}, ir[sel], 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k, cyc;
    int acc_cyc [3];
    logic seen;
    rst = 1'b1; kv = '0; iv = '0; in_decrypt = 1'b0; out_ready = 1'b1;
    key_bus = '0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_key_ready", kr[0], 1);
    check("rst_in_ready", ir[0], 0);
    check("rst_out_valid", ov[0], 0);
    check("rst_out_data", od[0], '0);

    load_key(0, K_SEQ, 40, "k128");
    run_block(0, 1'b0, PT, CT128, 10, 0, "enc128");
    run_block(0, 1'b1, CT128, PT, 10, 0, "dec128");
    load_key(1, K_SEQ, 46, "k192");
    run_block(1, 1'b0, PT, CT192, 12, 0, "enc192");
    run_block(1, 1'b1, CT192, PT, 12, 0, "dec192");
    load_key(2, K_SEQ, 52, "k256");
    run_block(2, 1'b0, PT, CT256, 14, 0, "enc256");
    run_block(2, 1'b1, CT256, PT, 14, 0, "dec256");
    load_key(3, K_SEQ, 40, "k128e");
    run_block(3, 1'b1, PT, CT128, 10, 0, "noinv");

    run_block(0, 1'b0, PT, CT128, 10, 20, "bp");

    out_ready = 1'b1; in_data = PT; in_decrypt = 1'b0; iv[0] = 1'b1;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 200) begin
      if (ir[0]) begin acc_cyc[k] = cyc; k++; end
      tick();
      cyc++;
    end
    iv[0] = 1'b0;
    check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 12);
    check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 12);
    n = 0;
    while (!ov[0] && n < 200) begin tick(); n++; end
    check("b2b_data", od[0], CT128);
    tick();

    n = 0;
    while (!ir[0] && n < 200) begin tick(); n++; end
    key_bus = {K_APPC, 128'h0}; in_data = PT_APPC; in_decrypt = 1'b0;
    kv[0] = 1'b1; iv[0] = 1'b1;
    tick();
    kv[0] = 1'b0;
    check("simul_key_taken", kr[0], 0);
    check("simul_blk_wait", ir[0], 0);
    n = 0;
    while (!ir[0] && n < 200) begin tick(); n++; end
    check("simul_kexp_cycles", n, 40);
    tick();
    iv[0] = 1'b0;
    n = 1;
    while (!ov[0] && n < 200) begin tick(); n++; end
    check("simul_latency", n, 11);
    check("simul_data", od[0], CT_APPC);
    tick();

    key_bus = K_SEQ; kv[1] = 1'b1;
    tick();
    kv[1] = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_kexp_out_valid", ov[1], 0);
    check("rst_kexp_in_ready", ir[1], 0);
    check("rst_kexp_key_ready", kr[1], 1);

    load_key(0, K_SEQ, 40, "k128b");
    in_data = PT; in_decrypt = 1'b0; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_round_out_valid", ov[0], 0);
    check("rst_round_in_ready", ir[0], 0);
    check("rst_round_key_ready", kr[0], 1);
    check("rst_round_out_data", od[0], '0);
    seen = 1'b0;
    iv[0] = 1'b1;
    repeat (20) begin
      tick();
      if (ir[0] || ov[0]) seen = 1'b1;
    end
    iv[0] = 1'b0;
    check("nokey_in_ignored", seen, 0);
    load_key(0, K_SEQ, 40, "k128c");
    run_block(0, 1'b1, CT128, PT, 10, 0, "dec128_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
